// File: rtl/smi_mem_lib_read_burst_test_sink64.sv
// Read burst test sink: issues one read burst per test request and checks each
// returned 64-bit word against an init/increment counting sequence.
module smi_mem_lib_read_burst_test_sink64 #(
    parameter int ERR_COUNT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       testParamsValid,
    input  logic [63:0]                testParamBurstAddr,
    input  logic [31:0]                testParamBurstLen,
    input  logic [7:0]                 testParamBurstOpts,
    input  logic [63:0]                testParamDataInit,
    input  logic [63:0]                testParamDataIncr,
    output logic                       testParamsStop,
    output logic                       testDoneValid,
    output logic                       testDoneStatusOk,
    output logic [ERR_COUNT_WIDTH-1:0] testDoneErrorCount,
    input  logic                       testDoneStop,
    output logic                       readParamsValid,
    output logic [63:0]                readParamBurstAddr,
    output logic [31:0]                readParamBurstLen,
    output logic [7:0]                 readParamBurstOpts,
    input  logic                       readParamsStop,
    input  logic                       readDataValid,
    input  logic [63:0]                readDataValue,
    output logic                       readDataStop,
    input  logic                       readDoneValid,
    input  logic                       readDoneStatusOk,
    output logic                       readDoneStop
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SET_PARAMS = 2'd1,
        READ_DATA  = 2'd2,
        GET_STATUS = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [63:0]                addr_q, addr_d;
    logic [31:0]                len_q, len_d;
    logic [7:0]                 opts_q, opts_d;
    logic [63:0]                expected_q, expected_d;
    logic [63:0]                incr_q, incr_d;
    logic [31:0]                remaining_q, remaining_d;
    logic [ERR_COUNT_WIDTH-1:0] err_count_q, err_count_d;
    logic                       mismatch_q, mismatch_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        opts_d      = opts_q;
        expected_d  = expected_q;
        incr_d      = incr_q;
        remaining_d = remaining_q;
        err_count_d = err_count_q;
        mismatch_d  = mismatch_q;

        case (state_q)
            IDLE: begin
                // Track the request inputs every idle cycle so the accepting cycle captures them.
                addr_d      = testParamBurstAddr;
                len_d       = testParamBurstLen;
                opts_d      = testParamBurstOpts;
                expected_d  = testParamDataInit;
                incr_d      = testParamDataIncr;
                remaining_d = testParamBurstLen;
                err_count_d = '0;
                mismatch_d  = 1'b0;
                if (testParamsValid) begin
                    state_d = SET_PARAMS;
                end
            end
            SET_PARAMS: begin
                if (!readParamsStop) begin
                    state_d = (len_q == 32'd0) ? GET_STATUS : READ_DATA;
                end
            end
            READ_DATA: begin
                if (readDataValid) begin
                    if (readDataValue != expected_q) begin
                        mismatch_d = 1'b1;
                        if (err_count_q != {ERR_COUNT_WIDTH{1'b1}}) begin
                            err_count_d = err_count_q + ERR_COUNT_WIDTH'(1);
                        end
                    end
                    expected_d  = expected_q + incr_q;
                    remaining_d = remaining_q - 32'd1;
                    if (remaining_q == 32'd1) begin
                        state_d = GET_STATUS;
                    end
                end
            end
            GET_STATUS: begin
                if (readDoneValid && !testDoneStop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath carries no reset; Idle reloads it before every test.
    always_ff @(posedge clk) begin
        addr_q      <= addr_d;
        len_q       <= len_d;
        opts_q      <= opts_d;
        expected_q  <= expected_d;
        incr_q      <= incr_d;
        remaining_q <= remaining_d;
        err_count_q <= err_count_d;
        mismatch_q  <= mismatch_d;
    end

    assign testParamsStop     = (state_q != IDLE);
    assign readParamsValid    = (state_q == SET_PARAMS);
    assign readParamBurstAddr = addr_q;
    assign readParamBurstLen  = len_q;
    assign readParamBurstOpts = opts_q;
    assign readDataStop       = (state_q != READ_DATA);
    assign readDoneStop       = (state_q == GET_STATUS) ? testDoneStop : 1'b1;
    assign testDoneValid      = (state_q == GET_STATUS) & readDoneValid;
    assign testDoneStatusOk   = readDoneStatusOk & ~mismatch_q;
    assign testDoneErrorCount = err_count_q;

endmodule
